// File: rtl/fsm_empaque.sv
// fsm_empaque: counts sealed units into boxes, times the box close/done sequence, keeps a box total (optional drop counter via PACK_DROP_CNT_EN)
module fsm_empaque #(
  parameter int UNITS_PER_BOX = 4,
  parameter int CLOSE_TICKS   = 3,
  parameter int DONE_TICKS    = 2,
  parameter int TOTAL_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               sealed,
  input  logic               box_ready,
  output logic               empacando,
  output logic               cerrando,
  output logic               caja_lista,
  output logic               fault,
  output logic [3:0]         units_in_box,
  output logic [TOTAL_W-1:0] total_boxes,
  output logic [2:0]         state_packer
`ifdef PACK_DROP_CNT_EN
  ,
  output logic [7:0]         dropped_units
`endif
);
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LOAD  = 3'b001,
    CLOSE = 3'b010,
    DONE  = 3'b011,
    FAULT = 3'b100
  } state_t;
  state_t     state;
  logic [3:0] timer;
  logic       ready_m, ready_s, sealed_q, unit_evt;
  assign unit_evt     = sealed & ~sealed_q;
  assign state_packer = state;
  // box_ready synchronizer and sealed edge register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_m  <= 1'b0;
      ready_s  <= 1'b0;
      sealed_q <= 1'b0;
    end else begin
      ready_m  <= box_ready;
      ready_s  <= ready_m;
      sealed_q <= sealed;
    end
  end
  // packing sequence: load units, timed close, timed done, fault on box removal
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      units_in_box <= 4'd0;
      total_boxes  <= '0;
      timer        <= 4'd0;
    end else begin
      case (state)
        IDLE:
          if (ready_s) begin
            state        <= LOAD;
            units_in_box <= 4'd0;
          end
        LOAD:
          if (unit_evt) begin
            units_in_box <= units_in_box + 4'd1;
            if (units_in_box + 4'd1 == 4'(UNITS_PER_BOX)) begin
              state <= CLOSE;
              timer <= 4'(CLOSE_TICKS);
            end
          end else if (!ready_s) begin
            state <= FAULT;
          end
        CLOSE:
          if (tick) begin
            timer <= timer - 4'd1;
            if (timer == 4'd1) begin
              state       <= DONE;
              timer       <= 4'(DONE_TICKS);
              total_boxes <= total_boxes + TOTAL_W'(1);
            end
          end
        DONE:
          if (tick) begin
            timer <= timer - 4'd1;
            if (timer == 4'd1) begin
              units_in_box <= 4'd0;
              state        <= ready_s ? LOAD : IDLE;
            end
          end
        FAULT:
          if (tick && !ready_s) begin
            state        <= IDLE;
            units_in_box <= 4'd0;
          end
        default: state <= IDLE;
      endcase
    end
  end
  // LEDs are a registered decode of the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      empacando  <= 1'b0;
      cerrando   <= 1'b0;
      caja_lista <= 1'b0;
      fault      <= 1'b0;
    end else begin
      empacando  <= state == LOAD;
      cerrando   <= state == CLOSE;
      caja_lista <= state == DONE;
      fault      <= state == FAULT;
    end
  end
`ifdef PACK_DROP_CNT_EN
  // saturating count of unit events that arrive outside LOAD
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      dropped_units <= 8'd0;
    else if (unit_evt && state != LOAD && dropped_units != 8'hFF)
      dropped_units <= dropped_units + 8'd1;
  end
`endif
endmodule

// File: tb/tb_fsm_empaque.sv
// tb_fsm_empaque: scoreboard bench for fsm_empaque (also checks dropped_units when PACK_DROP_CNT_EN is defined)
module tb_fsm_empaque;
  logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, sealed = 1'b0, box_ready = 1'b0;
  logic       empacando, cerrando, caja_lista, fault;
  logic [3:0] units_in_box;
  logic [7:0] total_boxes;
  logic [2:0] state_packer;
`ifdef PACK_DROP_CNT_EN
  logic [7:0] dropped_units;
`endif
  fsm_empaque dut (
    .clk(clk), .rst(rst), .tick(tick), .sealed(sealed), .box_ready(box_ready),
    .empacando(empacando), .cerrando(cerrando), .caja_lista(caja_lista), .fault(fault),
    .units_in_box(units_in_box), .total_boxes(total_boxes), .state_packer(state_packer)
`ifdef PACK_DROP_CNT_EN
    , .dropped_units(dropped_units)
`endif
  );
  always #5 clk = ~clk;
  typedef enum int {S_STATE, S_UNITS, S_TOTAL, S_LEDS, S_DROP} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;
  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0;
  logic [7:0] exp_total = 8'd0;
  logic [7:0] exp_drop = 8'd0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] probe(input sel_t s);
    case (s)
      S_STATE: return {29'd0, state_packer};
      S_UNITS: return {28'd0, units_in_box};
      S_TOTAL: return {24'd0, total_boxes};
      S_LEDS:  return {28'd0, fault, caja_lista, cerrando, empacando};
`ifdef PACK_DROP_CNT_EN
      S_DROP:  return {24'd0, dropped_units};
`endif
      default: return 32'd0;
    endcase
  endfunction
  task automatic push(input string tag, input sel_t sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, probe(e.sel), e.val);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic seal();
    sealed = 1'b1;
    step(1);
    sealed = 1'b0;
    step(1);
  endtask
  task automatic pulse();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
  endtask
  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    int k = 0;
    while (state_packer !== target && k < budget) begin
      step(1);
      k++;
    end
    check(tag, {29'd0, state_packer}, {29'd0, target});
  endtask
  task automatic do_box();
    for (int i = 1; i <= 4; i++) begin
      seal();
      push("box_units", S_UNITS, i);
      drain();
    end
    push("box_close", S_STATE, 2);
    push("box_close_led", S_LEDS, 2);
    drain();
    pulse();
    pulse();
    push("box_close_hold", S_STATE, 2);
    drain();
    pulse();
    exp_total = exp_total + 8'd1;
    push("box_done", S_STATE, 3);
    push("box_total", S_TOTAL, exp_total);
    push("box_done_led", S_LEDS, 4);
    drain();
    pulse();
    push("box_done_hold", S_STATE, 3);
    drain();
    pulse();
    push("box_reload", S_STATE, 1);
    push("box_units_clr", S_UNITS, 0);
    drain();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    step(2);
    push("rst_state", S_STATE, 0);
    push("rst_units", S_UNITS, 0);
    push("rst_total", S_TOTAL, 0);
    push("rst_leds", S_LEDS, 0);
`ifdef PACK_DROP_CNT_EN
    push("rst_drop", S_DROP, 0);
`endif
    drain();
    rst = 1'b1;
    box_ready = 1'b1;
    wait_state("enter_load", 3'd1, 8);
    push("load_units", S_UNITS, 0);
    drain();
    step(1);
    push("load_led", S_LEDS, 1);
    drain();
    do_box();
    seal();
    seal();
    push("rm_units2", S_UNITS, 2);
    drain();
    box_ready = 1'b0;
    wait_state("rm_fault", 3'd4, 6);
    push("rm_units_hold", S_UNITS, 2);
    drain();
    step(1);
    push("rm_fault_led", S_LEDS, 8);
    step(3);
    push("rm_wait_tick", S_STATE, 4);
    drain();
    pulse();
    push("rm_idle", S_STATE, 0);
    push("rm_units_clr", S_UNITS, 0);
    drain();
    box_ready = 1'b1;
    wait_state("sim_load", 3'd1, 8);
    seal();
    push("sim_units1", S_UNITS, 1);
    drain();
    box_ready = 1'b0;
    step(2);
    sealed = 1'b1;
    step(1);
    push("sim_units2", S_UNITS, 2);
    push("sim_still_load", S_STATE, 1);
    drain();
    sealed = 1'b0;
    step(1);
    push("sim_fault", S_STATE, 4);
    drain();
    pulse();
    push("sim_idle", S_STATE, 0);
    drain();
    box_ready = 1'b1;
    wait_state("drop_load", 3'd1, 8);
    for (int i = 0; i < 4; i++) seal();
    push("drop_close", S_STATE, 2);
    drain();
    seal();
    seal();
    exp_drop = exp_drop + 8'd2;
    push("drop_units", S_UNITS, 4);
    push("drop_state", S_STATE, 2);
`ifdef PACK_DROP_CNT_EN
    push("drop_count", S_DROP, exp_drop);
`endif
    drain();
    repeat (5) pulse();
    exp_total = exp_total + 8'd1;
    push("drop_total", S_TOTAL, exp_total);
    push("drop_reload", S_STATE, 1);
    drain();
    sealed = 1'b1;
    step(5);
    sealed = 1'b0;
    step(1);
    push("level_units", S_UNITS, 1);
    drain();
    for (int i = 0; i < 3; i++) seal();
    repeat (5) pulse();
    exp_total = exp_total + 8'd1;
    push("level_total", S_TOTAL, exp_total);
    drain();
    do begin
      do_box();
    end while (exp_total != 8'd0);
    check("total_wrap", {24'd0, total_boxes}, 32'd0);
    for (int i = 0; i < 4; i++) seal();
    push("rst_mid_close", S_STATE, 2);
    drain();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    push("arst_state", S_STATE, 0);
    push("arst_units", S_UNITS, 0);
    push("arst_total", S_TOTAL, 0);
    push("arst_leds", S_LEDS, 0);
`ifdef PACK_DROP_CNT_EN
    push("arst_drop", S_DROP, 0);
`endif
    drain();
    step(1);
    rst = 1'b1;
    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fsm_empaque.md
Name: fsm_empaque

Overview:
- Packing stage directly downstream of the fill/seal controller.
- Consumes the "seal finished" level (LED output of the fill/seal stage) and counts sealed units into a box of UNITS_PER_BOX.
- Closes the box over a timed sequence, signals box-done, keeps a running box total, and exposes its state on LEDs.
- Runs on the board clock; a 1 Hz tick enable from the prescaler paces the timers.

Parameters:
- UNITS_PER_BOX, 4, sealed units per box; legal range 1..15.
- CLOSE_TICKS, 3, tick periods spent in CLOSE; legal range 1..15.
- DONE_TICKS, 2, tick periods spent in DONE; legal range 1..15.
- TOTAL_W, 8, width of the box total counter.

Ports:
- clk  in  1  board clock (100 MHz).
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- tick  in  1  one-clk-wide enable pulse at 1 Hz from the prescaler.
- sealed  in  1  seal-finished level from the fill/seal stage.
- box_ready  in  1  switch: empty box present on the packing table.
- empacando  out  1  LED, high in LOAD.
- cerrando  out  1  LED, high in CLOSE.
- caja_lista  out  1  LED, high in DONE.
- fault  out  1  LED, high in FAULT.
- units_in_box  out  4  units loaded into the current box.
- total_boxes  out  TOTAL_W  completed boxes since reset.
- state_packer  out  3  current state encoding.

Behaviour:
- Everything is clocked on clk. Timers decrement only in cycles where tick=1.
- box_ready passes through a 2-flop synchronizer before use. sealed is registered once.
- unit_evt = sealed & ~sealed_q, i.e. one pulse per rising edge of sealed.
- Reset (rst=0, asynchronous) forces:
  - state = IDLE, all LEDs 0, units_in_box 0, total_boxes 0, timer 0;
  - synchronizer and edge registers to 0.
  - A reset asserted mid-operation abandons the box in progress; the partial count is discarded.
- States and encodings: IDLE=000, LOAD=001, CLOSE=010, DONE=011, FAULT=100.
- IDLE:
  - Moves to LOAD on the first clk with synced box_ready=1; units_in_box is cleared to 0.
- LOAD:
  - Each unit_evt increments units_in_box.
  - On the unit_evt that makes the count reach UNITS_PER_BOX, move to CLOSE and load timer = CLOSE_TICKS.
  - If synced box_ready=0 and no unit_evt arrives that cycle, move to FAULT.
  - If box_ready falls in the same cycle as a unit_evt, the unit counts first; FAULT is then taken on the next clk.
- CLOSE:
  - Timer decrements on each tick.
  - On the tick that takes the timer from 1 to 0: move to DONE, load timer = DONE_TICKS, and increment total_boxes.
  - unit_evt is ignored. box_ready is ignored; closing always completes.
- DONE:
  - Timer decrements on each tick.
  - On expiry: clear units_in_box, then move to LOAD if synced box_ready=1, otherwise to IDLE.
- FAULT:
  - units_in_box holds its value for inspection.
  - Moves to IDLE once synced box_ready=0 and one tick has elapsed; units_in_box is cleared on that exit.
- unit_evt outside LOAD is dropped; no count changes.
- total_boxes wraps modulo 2^TOTAL_W (255 -> 0 with the default width).
- LED outputs are a registered decode of the state, so they update on the clk after each transition.
- state_packer equals the state register.

Optional Feature:
- Macro PACK_DROP_CNT_EN.
- Defined:
  - adds output port dropped_units (8 bits, reset 0);
  - it increments on every unit_evt not consumed in LOAD and saturates at 255.
- Undefined: the port and counter do not exist; drops are silent. All other behaviour is identical.

Test Plan:
- Reset mid-CLOSE: pulse rst=0 while state=010 -> all outputs return to 0 and state=000 asynchronously, before the next clk edge.
- Normal box with defaults: box_ready=1, then 4 rising edges of sealed ->
  - units_in_box steps 1,2,3,4;
  - state 001->010;
  - exactly 3 ticks later state=011, total_boxes=1;
  - 2 ticks later state=001 and units_in_box=0.
- Box removed: in LOAD with units_in_box=2, drop box_ready ->
  - state=100, fault=1, units_in_box stays 2;
  - after box_ready=0 and one tick, state=000 and units_in_box=0.
- Simultaneous events: unit_evt and box_ready fall in the same clk, units_in_box=1 -> units_in_box=2, then FAULT on the next clk.
- Drops and wrap:
  - 2 sealed edges during CLOSE -> units_in_box unchanged; with PACK_DROP_CNT_EN, dropped_units=2.
  - Preload 255 completed boxes, finish one more -> total_boxes=0.
- Level sealed: hold sealed=1 for 5 clk in LOAD -> units_in_box increments by exactly 1.
